// File: rtl/conv2d_pkg.sv
// conv2d_pkg: shared types and helpers for the 2-D convolution engine.
//   state_t      : controller states (IDLE, RUN)
//   conv_out_dim : output size along one axis for a given kernel/stride/pad
//   cnt_w        : counter width able to index n items (at least 1 bit)
//   sat          : clamp a signed value into a signed field of 'width' bits
package conv2d_pkg;

    typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_t;

    function automatic int conv_out_dim(int in_dim, int k, int stride, int pad);
        return (in_dim + 2 * pad - k) / stride + 1;
    endfunction

    function automatic int cnt_w(int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    function automatic logic signed [63:0] sat(logic signed [63:0] value, int width);
        logic signed [63:0] hi;
        logic signed [63:0] lo;
        hi = (64'sd1 <<< (width - 1)) - 64'sd1;
        lo = -(64'sd1 <<< (width - 1));
        if (value > hi) return hi;
        if (value < lo) return lo;
        return value;
    endfunction

endpackage

// File: rtl/conv2d_window_mac.sv
// conv2d_window_mac: combinational computation of one output element.
// Gathers the kernel-sized window (zero outside the input bounds), multiplies
// each tap by its kernel weight, accumulates at full precision and saturates
// to DATA_SIZE bits.
//   in_map    in  : latched flattened input map
//   kern_flat in  : all kernel weights, element i at [i*DATA_SIZE +: DATA_SIZE]
//   oc/orow/ocol in : output channel / row / column being computed
//   result    out : saturated output element
module conv2d_window_mac
    import conv2d_pkg::*;
#(
    parameter int IN_CHANNELS  = 1,
    parameter int OUT_CHANNELS = 1,
    parameter int KERNEL_ROWS  = 3,
    parameter int KERNEL_COLS  = 3,
    parameter int STRIDE_ROWS  = 1,
    parameter int STRIDE_COLS  = 1,
    parameter int PAD_ROWS     = 0,
    parameter int PAD_COLS     = 0,
    parameter int INPUT_ROWS   = 5,
    parameter int INPUT_COLS   = 5,
    parameter int DATA_SIZE    = 8,
    parameter int OC_W         = 1,
    parameter int OR_W         = 2,
    parameter int OCOL_W       = 2
) (
    input  logic [INPUT_ROWS*INPUT_COLS*IN_CHANNELS*DATA_SIZE-1:0]            in_map,
    input  logic [OUT_CHANNELS*IN_CHANNELS*KERNEL_ROWS*KERNEL_COLS*DATA_SIZE-1:0] kern_flat,
    input  logic [OC_W-1:0]      oc,
    input  logic [OR_W-1:0]      orow,
    input  logic [OCOL_W-1:0]    ocol,
    output logic [DATA_SIZE-1:0] result
);

    // Wide enough for the worst-case sum of all taps; never overflows.
    localparam int ACC_W = 2 * DATA_SIZE + $clog2(IN_CHANNELS * KERNEL_ROWS * KERNEL_COLS);

    logic signed [ACC_W-1:0]       acc;
    logic signed [DATA_SIZE-1:0]   pix;
    logic signed [DATA_SIZE-1:0]   kv;
    logic signed [2*DATA_SIZE-1:0] prod;
    int r;
    int c;
    int kidx;
    int pidx;

    always_comb begin
        acc  = '0;
        pix  = '0;
        kv   = '0;
        prod = '0;
        r    = 0;
        c    = 0;
        kidx = 0;
        pidx = 0;
        for (int ic = 0; ic < IN_CHANNELS; ic++) begin
            for (int kr = 0; kr < KERNEL_ROWS; kr++) begin
                for (int kc = 0; kc < KERNEL_COLS; kc++) begin
                    r = int'(orow) * STRIDE_ROWS + kr - PAD_ROWS;
                    c = int'(ocol) * STRIDE_COLS + kc - PAD_COLS;
                    // Taps landing in the padding band contribute nothing.
                    if (r >= 0 && r < INPUT_ROWS && c >= 0 && c < INPUT_COLS) begin
                        pidx = (ic * INPUT_ROWS + r) * INPUT_COLS + c;
                        kidx = ((int'(oc) * IN_CHANNELS + ic) * KERNEL_ROWS + kr) * KERNEL_COLS + kc;
                        pix  = in_map[pidx*DATA_SIZE +: DATA_SIZE];
                        kv   = kern_flat[kidx*DATA_SIZE +: DATA_SIZE];
                        prod = pix * kv;
                        acc  = acc + ACC_W'(prod);
                    end
                end
            end
        end
        result = DATA_SIZE'(sat(64'(acc), DATA_SIZE));
    end

endmodule

// File: rtl/conv2d_core.sv
// conv2d_core: sequential 2-D convolution engine, one output element per clock.
//   clk, reset_n       : clock, asynchronous active-low reset
//   in                 : flattened input feature map, latched on accepted start
//   start              : begin a convolution (ignored while busy)
//   kern_we/addr/data  : kernel memory write port (ignored while busy)
//   busy               : computation in progress
//   done               : one-cycle pulse after the last element is written
//   out                : flattened output map, held between runs
module conv2d_core
    import conv2d_pkg::*;
#(
    parameter int IN_CHANNELS  = 1,
    parameter int OUT_CHANNELS = 1,
    parameter int KERNEL_ROWS  = 3,
    parameter int KERNEL_COLS  = 3,
    parameter int STRIDE_ROWS  = 1,
    parameter int STRIDE_COLS  = 1,
    parameter int PAD_ROWS     = 0,
    parameter int PAD_COLS     = 0,
    parameter int INPUT_ROWS   = 5,
    parameter int INPUT_COLS   = 5,
    parameter int DATA_SIZE    = 8,
    localparam int output_rows = conv_out_dim(INPUT_ROWS, KERNEL_ROWS, STRIDE_ROWS, PAD_ROWS),
    localparam int output_cols = conv_out_dim(INPUT_COLS, KERNEL_COLS, STRIDE_COLS, PAD_COLS),
    localparam int OUT_ELEMS   = output_rows * output_cols * OUT_CHANNELS,
    localparam int KERN_ELEMS  = OUT_CHANNELS * IN_CHANNELS * KERNEL_ROWS * KERNEL_COLS,
    localparam int KA_W        = cnt_w(KERN_ELEMS),
    localparam int IN_BITS     = INPUT_ROWS * INPUT_COLS * IN_CHANNELS * DATA_SIZE
) (
    input  logic                           clk,
    input  logic                           reset_n,
    input  logic [IN_BITS-1:0]             in,
    input  logic                           start,
    input  logic                           kern_we,
    input  logic [KA_W-1:0]                kern_addr,
    input  logic [DATA_SIZE-1:0]           kern_data,
    output logic                           busy,
    output logic                           done,
    output logic [OUT_ELEMS*DATA_SIZE-1:0] out
);

    localparam int OC_W   = cnt_w(OUT_CHANNELS);
    localparam int OR_W   = cnt_w(output_rows);
    localparam int OCOL_W = cnt_w(output_cols);
    localparam int EL_W   = cnt_w(OUT_ELEMS);

    state_t state, state_nxt;
    logic   accept, kern_wr, compute, last_elem;

    logic [IN_BITS-1:0]              in_q;
    logic [DATA_SIZE-1:0]            kernels [0:KERN_ELEMS-1];
    logic [KERN_ELEMS*DATA_SIZE-1:0] kern_flat;
    logic [OC_W-1:0]                 oc;
    logic [OR_W-1:0]                 orow;
    logic [OCOL_W-1:0]               ocol;
    logic [EL_W-1:0]                 elem;
    logic [DATA_SIZE-1:0]            mac_val;

    assign last_elem = (elem == EL_W'(OUT_ELEMS - 1));

    // ---------------- FSM ----------------
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state <= IDLE;
        else          state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start)     state_nxt = RUN;
            RUN:     if (last_elem) state_nxt = IDLE;
            default:                state_nxt = IDLE;
        endcase
    end

    always_comb begin
        busy    = (state == RUN);
        accept  = (state == IDLE) && start;
        kern_wr = (state == IDLE) && kern_we;
        compute = (state == RUN);
    end

    // ---------------- kernel memory ----------------
    // Left without reset so it can be preloaded by hierarchical name.
    always_ff @(posedge clk) begin
        if (kern_wr) kernels[kern_addr] <= kern_data;
    end

    for (genvar i = 0; i < KERN_ELEMS; i++) begin : g_kflat
        assign kern_flat[i*DATA_SIZE +: DATA_SIZE] = kernels[i];
    end

    // ---------------- datapath ----------------
    conv2d_window_mac #(
        .IN_CHANNELS (IN_CHANNELS),  .OUT_CHANNELS(OUT_CHANNELS),
        .KERNEL_ROWS (KERNEL_ROWS),  .KERNEL_COLS (KERNEL_COLS),
        .STRIDE_ROWS (STRIDE_ROWS),  .STRIDE_COLS (STRIDE_COLS),
        .PAD_ROWS    (PAD_ROWS),     .PAD_COLS    (PAD_COLS),
        .INPUT_ROWS  (INPUT_ROWS),   .INPUT_COLS  (INPUT_COLS),
        .DATA_SIZE   (DATA_SIZE),    .OC_W        (OC_W),
        .OR_W        (OR_W),         .OCOL_W      (OCOL_W)
    ) u_mac (
        .in_map   (in_q),
        .kern_flat(kern_flat),
        .oc       (oc),
        .orow     (orow),
        .ocol     (ocol),
        .result   (mac_val)
    );

    // elem tracks the flattened output index; the walk order (oc, row, col)
    // matches the output flattening so no index arithmetic is needed.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            in_q <= '0;
            oc   <= '0;
            orow <= '0;
            ocol <= '0;
            elem <= '0;
            out  <= '0;
            done <= 1'b0;
        end else begin
            done <= 1'b0;
            if (accept) in_q <= in;
            if (compute) begin
                out[int'(elem)*DATA_SIZE +: DATA_SIZE] <= mac_val;
                if (last_elem) begin
                    oc   <= '0;
                    orow <= '0;
                    ocol <= '0;
                    elem <= '0;
                    done <= 1'b1;
                end else begin
                    elem <= elem + 1'b1;
                    if (ocol == OCOL_W'(output_cols - 1)) begin
                        ocol <= '0;
                        if (orow == OR_W'(output_rows - 1)) begin
                            orow <= '0;
                            oc   <= oc + 1'b1;
                        end else begin
                            orow <= orow + 1'b1;
                        end
                    end else begin
                        ocol <= ocol + 1'b1;
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_conv2d_core.sv
// tb_conv2d_core: three engine instances (default, padded, strided) share one
// stimulus stream. A reference model tracks expected busy/done/out for each
// instance every cycle; literal expectations pin the model at key points.
module tb_conv2d_core;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic         reset_n, start, kern_we;
    logic [3:0]   kern_addr;
    logic [7:0]   kern_data;
    logic [199:0] in_vec;
    logic [2:0]   busy_w, done_w;
    logic [71:0]  o0;
    logic [199:0] o1;
    logic [31:0]  o2;
    logic [199:0] o_bus [3];

    assign o_bus[0] = {128'd0, o0};
    assign o_bus[1] = o1;
    assign o_bus[2] = {168'd0, o2};

    conv2d_core u_dut (
        .clk(clk), .reset_n(reset_n), .in(in_vec), .start(start),
        .kern_we(kern_we), .kern_addr(kern_addr), .kern_data(kern_data),
        .busy(busy_w[0]), .done(done_w[0]), .out(o0));

    conv2d_core #(.PAD_ROWS(1), .PAD_COLS(1)) u_pad (
        .clk(clk), .reset_n(reset_n), .in(in_vec), .start(start),
        .kern_we(kern_we), .kern_addr(kern_addr), .kern_data(kern_data),
        .busy(busy_w[1]), .done(done_w[1]), .out(o1));

    conv2d_core #(.STRIDE_ROWS(2), .STRIDE_COLS(2)) u_str (
        .clk(clk), .reset_n(reset_n), .in(in_vec), .start(start),
        .kern_we(kern_we), .kern_addr(kern_addr), .kern_data(kern_data),
        .busy(busy_w[2]), .done(done_w[2]), .out(o2));

    // Per-instance geometry: element count, output width, stride, padding.
    int n_el  [3] = '{9, 25, 4};
    int ocols [3] = '{3, 5, 2};
    int strd  [3] = '{1, 1, 2};
    int padv  [3] = '{0, 1, 0};

    int n_cmp = 0;
    int n_bad = 0;
    int lat [3];

    // Reference model state.
    bit m_run  [3];
    bit m_done [3];
    int m_k    [3];
    int m_out  [3][25];
    int m_snap [3][25];
    int m_kern [3][9];

    task automatic chk(string name, logic [199:0] act, logic [199:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic int model_elem(int i, int k);
        int orow = k / ocols[i];
        int ocol = k % ocols[i];
        int s = 0;
        int r, c;
        for (int kr = 0; kr < 3; kr++)
            for (int kc = 0; kc < 3; kc++) begin
                r = orow * strd[i] + kr - padv[i];
                c = ocol * strd[i] + kc - padv[i];
                if (r >= 0 && r < 5 && c >= 0 && c < 5)
                    s += m_snap[i][r*5+c] * m_kern[i][kr*3+kc];
            end
        if (s > 127)  s = 127;
        if (s < -128) s = -128;
        return s;
    endfunction

    // Compare process: at each falling edge check outputs against the model,
    // then advance the model using the inputs the next rising edge will see.
    initial begin
        logic [199:0] ev;
        bit nd;
        forever begin
            @(negedge clk);
            for (int i = 0; i < 3; i++) begin
                if (!reset_n) begin
                    m_run[i] = 0; m_done[i] = 0; m_k[i] = 0;
                    for (int e = 0; e < 25; e++) m_out[i][e] = 0;
                end
                ev = '0;
                for (int e = 0; e < n_el[i]; e++) ev[e*8 +: 8] = 8'(m_out[i][e]);
                chk($sformatf("busy[%0d]", i), 200'(busy_w[i]), 200'(m_run[i]));
                chk($sformatf("done[%0d]", i), 200'(done_w[i]), 200'(m_done[i]));
                chk($sformatf("out[%0d]", i), o_bus[i], ev);
                if (reset_n) begin
                    nd = 0;
                    if (m_run[i]) begin
                        m_out[i][m_k[i]] = model_elem(i, m_k[i]);
                        m_k[i]++;
                        if (m_k[i] == n_el[i]) begin m_run[i] = 0; nd = 1; end
                    end else begin
                        if (kern_we && kern_addr < 9) m_kern[i][kern_addr] = $signed(kern_data);
                        if (start) begin
                            m_run[i] = 1; m_k[i] = 0;
                            for (int e = 0; e < 25; e++) m_snap[i][e] = $signed(in_vec[e*8 +: 8]);
                        end
                    end
                    m_done[i] = nd;
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk); #1;
    endtask

    task automatic set_in(bit ramp, int v);
        for (int e = 0; e < 25; e++) in_vec[e*8 +: 8] = ramp ? 8'(e) : 8'(v);
    endtask

    task automatic load_kern(int v, bit center_only);
        for (int a = 0; a < 9; a++) begin
            kern_we = 1'b1; kern_addr = 4'(a);
            kern_data = 8'((center_only && a != 4) ? 0 : v);
            tick();
        end
        kern_we = 1'b0;
    endtask

    // Pulse start, record the cycle each instance raises done, check latency.
    task automatic run_all();
        lat = '{0, 0, 0};
        start = 1'b1; tick(); start = 1'b0;
        for (int cyc = 1; cyc <= 100; cyc++) begin
            tick();
            for (int i = 0; i < 3; i++) if (done_w[i] && lat[i] == 0) lat[i] = cyc;
            if (lat[0] != 0 && lat[1] != 0 && lat[2] != 0) break;
        end
        for (int i = 0; i < 3; i++) chk($sformatf("latency[%0d]", i), 200'(lat[i]), 200'(n_el[i]));
    endtask

    task automatic wait_idle();
        for (int cyc = 0; cyc < 100 && busy_w != 3'b000; cyc++) tick();
        chk("idle_timeout", 200'(busy_w), 200'(0));
    endtask

    initial begin
        reset_n = 1'b1; start = 1'b0; kern_we = 1'b0;
        kern_addr = '0; kern_data = '0; in_vec = '0;
        #2 reset_n = 1'b0;
        repeat (2) tick();
        reset_n = 1'b1;
        tick();
        chk("reset_busy", 200'(busy_w), 200'(0));
        chk("reset_out0", o_bus[0], 200'(0));

        // All-ones input and kernel.
        set_in(0, 1); load_kern(1, 0); run_all();
        chk("ones_dut", o_bus[0], 200'({9{8'd9}}));
        chk("ones_pad_corner", 200'(o1[7:0]), 200'(4));
        chk("ones_pad_edge", 200'(o1[15:8]), 200'(6));
        chk("ones_pad_center", 200'(o1[12*8 +: 8]), 200'(9));
        chk("ones_pad_lastcorner", 200'(o1[24*8 +: 8]), 200'(4));
        chk("ones_str", o_bus[2], 200'({4{8'd9}}));

        // Ramp input, center-tap kernel.
        set_in(1, 0); load_kern(1, 1); run_all();
        chk("ramp_dut", o_bus[0],
            200'({8'd18, 8'd17, 8'd16, 8'd13, 8'd12, 8'd11, 8'd8, 8'd7, 8'd6}));
        chk("ramp_str", o_bus[2], 200'({8'd18, 8'd16, 8'd8, 8'd6}));
        chk("ramp_pad", o_bus[1], in_vec);

        // Saturation both ways.
        set_in(0, 127); load_kern(1, 0); run_all();
        chk("sat_pos", o_bus[0], 200'({9{8'h7f}}));
        load_kern(-1, 0); run_all();
        chk("sat_neg", o_bus[0], 200'({9{8'h80}}));
        chk("sat_neg_pad", o_bus[1], {25{8'h80}});

        // start and kernel write mid-run are both ignored.
        set_in(0, 1); load_kern(1, 0);
        start = 1'b1; tick(); start = 1'b0;
        repeat (2) tick();
        start = 1'b1; set_in(1, 0);
        kern_we = 1'b1; kern_addr = 4'd4; kern_data = 8'd5;
        tick();
        start = 1'b0; kern_we = 1'b0; set_in(0, 1);
        wait_idle();
        chk("midrun_dut", o_bus[0], 200'({9{8'd9}}));

        // Back-to-back: start accepted in the done cycle; kernel still all ones.
        start = 1'b1; tick(); start = 1'b0;
        for (int cyc = 0; cyc < 20 && !done_w[0]; cyc++) tick();
        chk("b2b_done", 200'(done_w[0]), 200'(1));
        start = 1'b1; tick(); start = 1'b0;
        chk("b2b_busy", 200'(busy_w[0]), 200'(1));
        wait_idle();
        chk("b2b_dut", o_bus[0], 200'({9{8'd9}}));

        // Reset mid-run clears everything immediately.
        set_in(1, 0);
        start = 1'b1; tick(); start = 1'b0;
        repeat (3) tick();
        reset_n = 1'b0;
        #1;
        chk("rst_busy", 200'(busy_w), 200'(0));
        chk("rst_done", 200'(done_w), 200'(0));
        chk("rst_out0", o_bus[0], 200'(0));
        chk("rst_out1", o_bus[1], 200'(0));
        chk("rst_out2", o_bus[2], 200'(0));
        tick();
        reset_n = 1'b1;
        repeat (2) tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
